// File: rtl/calc_pkg.sv
// Shared calculator types: BCD floating-point number, ALU opcode and digit helpers.
package calc_pkg;

    localparam int unsigned NumDigits = 8;
    localparam int unsigned ExpWidth  = 8;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

    typedef struct packed {
        logic                       sign;
        logic signed [ExpWidth-1:0] exponent;
        logic [NumDigits*4-1:0]     sig;
    } num_t;

    function automatic logic isZero(num_t n);
        return n.sig == '0;
    endfunction

    // Returns {carry_out, digit}.
    function automatic logic [4:0] bcdAddDigit(bcd_digit_t a, bcd_digit_t b, logic cin);
        logic [4:0] t;
        t = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        if (t > 5'd9) return {1'b1, 4'(t - 5'd10)};
        return {1'b0, t[3:0]};
    endfunction

    // Returns {borrow_out, digit}.
    function automatic logic [4:0] bcdSubDigit(bcd_digit_t a, bcd_digit_t b, logic bin);
        logic [5:0] t;
        t = {2'b0, a} - {2'b0, b} - {5'b0, bin};
        if (t[5]) return {1'b1, 4'(t + 6'd10)};
        return {1'b0, t[3:0]};
    endfunction

endpackage

// File: rtl/calc_bcd_digit_addsub.sv
// Combinational single BCD digit adder/subtractor with carry/borrow in and out.
module calc_bcd_digit_addsub
    import calc_pkg::*;
(
    input  bcd_digit_t a_i,
    input  bcd_digit_t b_i,
    input  logic       cin_i,
    input  logic       sub_i,
    output bcd_digit_t s_o,
    output logic       cout_o
);

    logic [4:0] res;

    always_comb begin
        res    = sub_i ? bcdSubDigit(a_i, b_i, cin_i) : bcdAddDigit(a_i, b_i, cin_i);
        s_o    = res[3:0];
        cout_o = res[4];
    end

endmodule

// File: rtl/calc_bcd_alu.sv
// Multi-cycle BCD floating-point ALU (add/sub/mul/div) behind a valid/ready handshake.
// Division datapath is present only when CALC_ALU_DIV_EN is defined.
module calc_bcd_alu
    import calc_pkg::*;
#(
    parameter int unsigned NumDigits = calc_pkg::NumDigits,
    parameter int unsigned ExpW      = calc_pkg::ExpWidth
) (
    input  logic clk_i,
    input  logic rst_i,
    input  num_t left_i,
    input  num_t right_i,
    input  op_t  op_i,
    input  logic in_valid_i,
    output logic in_ready_o,
    output num_t result_o,
    output logic overflow_o,
    output logic out_valid_o,
    input  logic out_ready_i
);

    localparam int unsigned W  = 4 * NumDigits;
    localparam int unsigned EW = ExpW + 2;

    typedef logic signed [EW-1:0] exp_t;
    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADDSUB, S_MUL, S_DIV, S_NORM, S_DONE} state_t;

    localparam exp_t       EZero   = '0;
    localparam exp_t       EOne    = exp_t'(1);
    localparam exp_t       ENum    = exp_t'(NumDigits);
    localparam exp_t       EMax    = exp_t'(NumDigits - 1);
    localparam exp_t       EMin    = -EMax;
    localparam logic [7:0] CntLast = 8'(NumDigits - 1);

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [3:0]     mc_q, mc_d;
    exp_t           e_q, e_d, eb_q, eb_d;
    logic           sa_q, sa_d, sb_q, sb_d, carry_q, carry_d, ovf_q, ovf_d;
    logic [7:0]     cnt_q, cnt_d;
    num_t           res_q, res_d;
`ifdef CALC_ALU_DIV_EN
    logic [3:0]     qd_q, qd_d;
    logic           q0nz_q, q0nz_d;
`endif

    // Digit-serial unit for add/sub; parallel chain for mul/div partial steps.
    bcd_digit_t     ser_s;
    logic           ser_c;
    logic [W-1:0]   ch_y, ch_s;
    logic [NumDigits:0] ch_c;
    logic           ch_sub;

    calc_bcd_digit_addsub u_serial (
        .a_i   (a_q[3:0]),
        .b_i   (b_q[3:0]),
        .cin_i (carry_q),
        .sub_i (sa_q ^ sb_q),
        .s_o   (ser_s),
        .cout_o(ser_c)
    );

    assign ch_c[0] = 1'b0;
    for (genvar g = 0; g < NumDigits; g++) begin : g_chain
        calc_bcd_digit_addsub u_digit (
            .a_i   (acc_q[W+4*g +: 4]),
            .b_i   (ch_y[4*g +: 4]),
            .cin_i (ch_c[g]),
            .sub_i (ch_sub),
            .s_o   (ch_s[4*g +: 4]),
            .cout_o(ch_c[g+1])
        );
    end

    always_comb begin
        ch_y   = a_q;
        ch_sub = 1'b0;
`ifdef CALC_ALU_DIV_EN
        if (state_q == S_DIV) begin
            ch_y   = b_q;
            ch_sub = 1'b1;
        end
`endif
    end

    logic [3:0]     mul_top;
    logic [2*W-1:0] acc_sh;
    logic [W-1:0]   a_nxt;
    exp_t           diff;

    assign mul_top = mc_q + {3'b0, ch_c[NumDigits]};
    assign acc_sh  = {mc_q, acc_q[2*W-1:4]};
    assign a_nxt   = {ser_s, a_q[W-1:4]};
    assign diff    = e_q - eb_q;
`ifdef CALC_ALU_DIV_EN
    logic [3:0] div_top;
    logic       div_borrow;
    assign div_top    = mc_q - {3'b0, ch_c[NumDigits]};
    assign div_borrow = (mc_q == 4'd0) && ch_c[NumDigits];
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        mc_d    = mc_q;
        e_d     = e_q;
        eb_d    = eb_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
`ifdef CALC_ALU_DIV_EN
        qd_d    = qd_q;
        q0nz_d  = q0nz_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    a_d     = left_i.sig;
                    b_d     = right_i.sig;
                    sa_d    = left_i.sign;
                    sb_d    = right_i.sign ^ (op_i == OP_SUB);
                    e_d     = exp_t'($signed(left_i.exponent));
                    eb_d    = exp_t'($signed(right_i.exponent));
                    acc_d   = '0;
                    mc_d    = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
`ifdef CALC_ALU_DIV_EN
                    qd_d    = '0;
                    q0nz_d  = 1'b0;
`endif
                    case (op_i)
                        OP_MUL: begin
                            e_d     = exp_t'($signed(left_i.exponent))
                                    + exp_t'($signed(right_i.exponent));
                            state_d = S_MUL;
                        end
                        OP_DIV: begin
`ifdef CALC_ALU_DIV_EN
                            if (isZero(right_i)) begin
                                res_d   = '0;
                                ovf_d   = 1'b1;
                                state_d = S_DONE;
                            end else begin
                                acc_d[2*W-1:W] = left_i.sig;
                                e_d     = exp_t'($signed(left_i.exponent))
                                        - exp_t'($signed(right_i.exponent));
                                state_d = S_DIV;
                            end
`else
                            res_d   = '0;
                            ovf_d   = 1'b1;
                            state_d = S_DONE;
`endif
                        end
                        default: state_d = S_ALIGN;
                    endcase
                end
            end
            S_ALIGN: begin
                if (diff == EZero) begin
                    // Effective subtract: larger magnitude goes to a, keeping its sign.
                    if ((sa_q != sb_q) && (b_q > a_q)) begin
                        a_d  = b_q;
                        b_d  = a_q;
                        sa_d = sb_q;
                        sb_d = sa_q;
                    end
                    state_d = S_ADDSUB;
                end else if (diff >= ENum) begin
                    b_d  = '0;
                    eb_d = e_q;
                end else if (diff > EZero) begin
                    b_d  = b_q >> 4;
                    eb_d = eb_q + EOne;
                end else if (diff <= -ENum) begin
                    a_d = '0;
                    e_d = eb_q;
                end else begin
                    a_d = a_q >> 4;
                    e_d = e_q + EOne;
                end
            end
            S_ADDSUB: begin
                a_d     = a_nxt;
                b_d     = b_q >> 4;
                carry_d = ser_c;
                cnt_d   = cnt_q + 8'd1;
                if (cnt_q == CntLast) begin
                    if (ser_c && (sa_q == sb_q)) begin
                        a_d = {4'd1, a_nxt[W-1:4]};
                        e_d = e_q + EOne;
                    end
                    state_d = S_NORM;
                end
            end
            S_MUL: begin
                if (b_q[3:0] != 4'd0) begin
                    mc_d             = mul_top;
                    acc_d[2*W-1:W]   = ch_s;
                    b_d[3:0]         = b_q[3:0] - 4'd1;
                end else begin
                    acc_d = acc_sh;
                    mc_d  = '0;
                    b_d   = b_q >> 4;
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == CntLast) begin
                        if (acc_sh[2*W-1:2*W-4] != 4'd0) begin
                            a_d = acc_sh[2*W-1:W];
                            e_d = e_q + EOne;
                        end else begin
                            a_d = acc_sh[2*W-5:W-4];
                        end
                        sa_d    = sa_q ^ sb_q;
                        state_d = S_NORM;
                    end
                end
            end
`ifdef CALC_ALU_DIV_EN
            S_DIV: begin
                if (!div_borrow) begin
                    mc_d           = div_top;
                    acc_d[2*W-1:W] = ch_s;
                    qd_d           = qd_q + 4'd1;
                end else begin
                    // Remainder times ten; quotient digit shifted into a.
                    a_d            = {a_q[W-5:0], qd_q};
                    mc_d           = acc_q[2*W-1:2*W-4];
                    acc_d[2*W-1:W] = {acc_q[2*W-5:W], 4'd0};
                    qd_d           = '0;
                    cnt_d          = cnt_q + 8'd1;
                    if (cnt_q == 8'd0) q0nz_d = (qd_q != 4'd0);
                    if ((cnt_q == 8'(NumDigits)) || ((cnt_q == CntLast) && q0nz_q)) begin
                        if (!q0nz_q) e_d = e_q - EOne;
                        sa_d    = sa_q ^ sb_q;
                        state_d = S_NORM;
                    end
                end
            end
`endif
            S_NORM: begin
                if (a_q == '0) begin
                    res_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_DONE;
                end else if (a_q[W-1:W-4] == 4'd0) begin
                    a_d = a_q << 4;
                    e_d = e_q - EOne;
                end else if ((e_q > EMax) || (e_q < EMin)) begin
                    res_d   = '0;
                    ovf_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    res_d.sign     = sa_q;
                    res_d.exponent = e_q[ExpW-1:0];
                    res_d.sig      = a_q;
                    state_d        = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            mc_q    <= '0;
            e_q     <= '0;
            eb_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
`ifdef CALC_ALU_DIV_EN
            qd_q    <= '0;
            q0nz_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            mc_q    <= mc_d;
            e_q     <= e_d;
            eb_q    <= eb_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
`ifdef CALC_ALU_DIV_EN
            qd_q    <= qd_d;
            q0nz_q  <= q0nz_d;
`endif
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = (state_q == S_DONE);
    assign result_o    = res_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_calc_bcd_alu.sv
// Scoreboard bench for calc_bcd_alu; expected results are hand-computed constants.
module tb_calc_bcd_alu;
    import calc_pkg::*;

    localparam int Budget = 12 * NumDigits + 4;

    typedef struct packed {
        logic ovf;
        num_t n;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    num_t left_v = '0, right_v = '0;
    op_t  op_v = OP_ADD;
    logic in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, overflow, out_valid;
    num_t result;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    calc_bcd_alu dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .left_i     (left_v),
        .right_i    (right_v),
        .op_i       (op_v),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .result_o   (result),
        .overflow_o (overflow),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic num_t mk(input logic s, input int e, input logic [31:0] sig);
        num_t n;
        n.sign     = s;
        n.exponent = ExpWidth'(e);
        n.sig      = sig;
        return n;
    endfunction

    // Called #1 after a rising edge with the DUT idle.
    task automatic run_op(input string tag, input num_t l, input num_t r, input op_t o,
                          input num_t en, input logic eo, input int hold, input int lat);
        exp_t e;
        int   cycles;
        left_v   = l;
        right_v  = r;
        op_v     = o;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sb.push_back('{ovf: eo, n: en});
        cycles = 0;
        while (!out_valid && cycles < Budget) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check_val({tag, " valid"}, 64'(out_valid), 64'd1);
        e = sb.pop_front();
        check_val({tag, " result"}, 64'(result), 64'(e.n));
        check_val({tag, " ovf"}, 64'(overflow), 64'(e.ovf));
        if (lat >= 0) check_val({tag, " latency"}, 64'(cycles), 64'(lat));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_val({tag, " hold result"}, 64'(result), 64'(e.n));
            check_val({tag, " hold ready"}, 64'(in_ready), 64'd0);
            check_val({tag, " hold valid"}, 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_val({tag, " idle after"}, 64'(in_ready), 64'd1);
    endtask

    num_t zero;

    initial begin
        zero = '0;
        #12;
        check_val("reset in_ready", 64'(in_ready), 64'd1);
        check_val("reset out_valid", 64'(out_valid), 64'd0);
        check_val("reset result", 64'(result), 64'd0);
        check_val("reset ovf", 64'(overflow), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("add", mk(0, 0, 32'h15000000), mk(0, 0, 32'h25000000), OP_ADD,
               mk(0, 0, 32'h40000000), 1'b0, 0, -1);
        run_op("add carry", mk(0, 0, 32'h90000000), mk(0, 0, 32'h10000000), OP_ADD,
               mk(0, 1, 32'h10000000), 1'b0, 0, -1);
        run_op("align drop", mk(0, 3, 32'h10000000), mk(0, -NumDigits, 32'h10000000), OP_ADD,
               mk(0, 3, 32'h10000000), 1'b0, 0, -1);
        run_op("sub neg", mk(0, 0, 32'h30000000), mk(0, 0, 32'h50000000), OP_SUB,
               mk(1, 0, 32'h20000000), 1'b0, 0, -1);
        run_op("sub zero", mk(0, 0, 32'h20000000), mk(0, 0, 32'h20000000), OP_SUB,
               zero, 1'b0, 0, -1);
        run_op("sub align", mk(0, 2, 32'h75000000), mk(0, 1, 32'h25000000), OP_SUB,
               mk(0, 2, 32'h72500000), 1'b0, 0, -1);
        run_op("mul", mk(0, 0, 32'h40000000), mk(0, 0, 32'h25000000), OP_MUL,
               mk(0, 1, 32'h10000000), 1'b0, 0, -1);
        run_op("mul sign", mk(1, 0, 32'h30000000), mk(0, 0, 32'h20000000), OP_MUL,
               mk(1, 0, 32'h60000000), 1'b0, 0, -1);
        run_op("mul ovf", mk(0, 5, 32'h50000000), mk(0, 5, 32'h50000000), OP_MUL,
               zero, 1'b1, 0, -1);
        run_op("hold", mk(0, 0, 32'h15000000), mk(0, 0, 32'h25000000), OP_ADD,
               mk(0, 0, 32'h40000000), 1'b0, 20, -1);
`ifdef CALC_ALU_DIV_EN
        run_op("div quarter", mk(0, 0, 32'h10000000), mk(0, 0, 32'h40000000), OP_DIV,
               mk(0, -1, 32'h25000000), 1'b0, 0, -1);
        run_op("div third", mk(0, 0, 32'h10000000), mk(0, 0, 32'h30000000), OP_DIV,
               mk(0, -1, 32'h33333333), 1'b0, 0, -1);
        run_op("div exact", mk(1, 0, 32'h90000000), mk(0, 0, 32'h30000000), OP_DIV,
               mk(1, 0, 32'h30000000), 1'b0, 0, -1);
        run_op("div zero", mk(0, 0, 32'h10000000), zero, OP_DIV, zero, 1'b1, 0, 0);
`else
        run_op("div off", mk(0, 0, 32'h10000000), mk(0, 0, 32'h40000000), OP_DIV,
               zero, 1'b1, 0, 0);
`endif

        // Abort a long multiply with reset.
        left_v   = mk(0, 0, 32'h99999999);
        right_v  = mk(0, 0, 32'h99999999);
        op_v     = OP_MUL;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sb.push_back('{ovf: 1'b0, n: zero});
        repeat (5) @(posedge clk);
        #1;
        check_val("pre-reset busy", 64'(in_ready), 64'd0);
        rst = 1'b1;
        #1;
        check_val("mid reset valid", 64'(out_valid), 64'd0);
        check_val("mid reset ready", 64'(in_ready), 64'd1);
        void'(sb.pop_back());
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_op("post reset mul", mk(0, 0, 32'h12000000), mk(0, 0, 32'h30000000), OP_MUL,
               mk(0, 0, 32'h36000000), 1'b0, 0, -1);

        check_val("scoreboard empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
